// File: rtl/pulse_window_counter.sv
// Counts rising edges of din over back-to-back windows of win_len cycles and
// hands each window's count to a single-entry valid/ready output register.
module pulse_window_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic [WIN_W-1:0] win_len,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_drop
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e             state_q;
  logic               din_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [WIN_W-1:0]   remaining_q;
  logic [WIN_W-1:0]   loadLen;
  logic               winOvf_q;
  logic               winOvf_d;
  logic [CNT_W-1:0]   outCount_q;
  logic               outOvf_q;
  logic               outValid_q;
  logic               outDrop_q;
  logic               rise;
  logic               atMax;
  logic               winDone;

  assign rise     = din & ~din_q;
  assign atMax    = (count_q == {CNT_W{1'b1}});
  assign count_d  = (rise && !atMax) ? count_q + CNT_W'(1) : count_q;
  assign winOvf_d = winOvf_q | (rise & atMax);
  // A zero length still yields a one-cycle window rather than a stuck counter.
  assign loadLen  = (win_len == '0) ? WIN_W'(1) : win_len;
  assign winDone  = (state_q == RUN) && en && (remaining_q == WIN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      din_q       <= 1'b0;
      count_q     <= '0;
      remaining_q <= '0;
      winOvf_q    <= 1'b0;
      outCount_q  <= '0;
      outOvf_q    <= 1'b0;
      outValid_q  <= 1'b0;
      outDrop_q   <= 1'b0;
    end else begin
      din_q <= din;

      case (state_q)
        IDLE: begin
          if (en) begin
            state_q     <= RUN;
            remaining_q <= loadLen;
            count_q     <= '0;
            winOvf_q    <= 1'b0;
          end
        end
        RUN: begin
          if (!en) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            count_q     <= '0;
            winOvf_q    <= 1'b0;
          end else if (remaining_q == WIN_W'(1)) begin
            remaining_q <= loadLen;
            count_q     <= '0;
            winOvf_q    <= 1'b0;
          end else begin
            remaining_q <= remaining_q - WIN_W'(1);
            count_q     <= count_d;
            winOvf_q    <= winOvf_d;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A finished window may replace the held result only if it leaves this cycle.
      if (winDone) begin
        if (!outValid_q || out_ready) begin
          outCount_q <= count_d;
          outOvf_q   <= winOvf_d;
          outValid_q <= 1'b1;
        end else begin
          outDrop_q <= 1'b1;
        end
      end else if (outValid_q && out_ready) begin
        outValid_q <= 1'b0;
      end
    end
  end

  assign out_count = outCount_q;
  assign out_ovf   = outOvf_q;
  assign out_valid = outValid_q;
  assign out_drop  = outDrop_q;

endmodule

// File: tb/tb_pulse_window_counter.sv
// Directed bench for pulse_window_counter: a window-level reference model checked
// every cycle, plus hand-computed expectations at the interesting points.
module tb_pulse_window_counter;

  localparam int CNT_W = 8;
  localparam int WIN_W = 16;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             din = 1'b0;
  logic [WIN_W-1:0] win_len = '0;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_valid;
  logic             out_drop;

  int numChecks = 0;
  int numFails  = 0;
  bit checkOn   = 1'b0;

  // Reference state: whether a window is open, cycles left, raw (unsaturated) rises.
  bit mRunning = 1'b0;
  int mLeft    = 0;
  int mRises   = 0;
  bit mPrevDin = 1'b0;
  bit expValid = 1'b0;
  int expCount = 0;
  bit expOvf   = 1'b0;
  bit expDrop  = 1'b0;

  pulse_window_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .din(din),
    .win_len(win_len),
    .out_count(out_count),
    .out_ovf(out_ovf),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_drop(out_drop)
  );

  always #5 clk = ~clk;

  // The model sees the same inputs the DUT samples at this edge.
  always @(posedge clk) begin : model
    bit completed;
    int res;
    bit resOvf;
    completed = 1'b0;
    res = 0;
    resOvf = 1'b0;
    if (rst) begin
      mRunning = 1'b0;
      mLeft = 0;
      mRises = 0;
      expValid = 1'b0;
      expCount = 0;
      expOvf = 1'b0;
      expDrop = 1'b0;
      mPrevDin = 1'b0;
    end else begin
      if (mRunning) begin
        if (!en) begin
          mRunning = 1'b0;
        end else begin
          if (din && !mPrevDin) mRises++;
          mLeft--;
          if (mLeft == 0) begin
            completed = 1'b1;
            res = (mRises > MAXC) ? MAXC : mRises;
            resOvf = (mRises > MAXC);
            mLeft = (win_len == 0) ? 1 : int'(win_len);
            mRises = 0;
          end
        end
      end else if (en) begin
        mRunning = 1'b1;
        mLeft = (win_len == 0) ? 1 : int'(win_len);
        mRises = 0;
      end
      if (completed) begin
        if (!expValid || out_ready) begin
          expValid = 1'b1;
          expCount = res;
          expOvf = resOvf;
        end else begin
          expDrop = 1'b1;
        end
      end else if (expValid && out_ready) begin
        expValid = 1'b0;
      end
      mPrevDin = din;
    end
  end

  task automatic compareOne(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      compareOne("model.out_valid", 32'(out_valid), 32'(expValid));
      compareOne("model.out_drop", 32'(out_drop), 32'(expDrop));
      if (expValid) begin
        compareOne("model.out_count", 32'(out_count), 32'(expCount));
        compareOne("model.out_ovf", 32'(out_ovf), 32'(expOvf));
      end
    end
  end

  task automatic applyStimulus(input bit r, input bit e, input bit d, input int len, input bit rdy);
    rst = r;
    en = e;
    din = d;
    win_len = WIN_W'(len);
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int cnt, input bit ovf, input bit valid, input bit drop);
    compareOne({name, ".valid"}, 32'(out_valid), 32'(valid));
    compareOne({name, ".drop"}, 32'(out_drop), 32'(drop));
    compareOne({name, ".count"}, 32'(out_count), 32'(cnt));
    compareOne({name, ".ovf"}, 32'(out_ovf), 32'(ovf));
  endtask

  initial begin
    bit pat[4];
    // Reset with active inputs: reset must win.
    applyStimulus(1, 1, 1, 4, 1);
    applyStimulus(1, 1, 1, 4, 1);
    checkOn = 1'b1;
    checkOutput("reset", 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 4, 1);

    // Length-4 windows, din 1,0,1,0 gives two rises, no gap between windows.
    $display("[TB] basic length-4 windows");
    pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    applyStimulus(0, 1, 0, 4, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, pat[i], 4, 1);
    checkOutput("win4.first", 2, 0, 1, 0);
    applyStimulus(0, 1, pat[0], 4, 1);
    checkOutput("win4.accepted", 2, 0, 0, 0);
    for (int i = 1; i < 4; i++) applyStimulus(0, 1, pat[i], 4, 1);
    checkOutput("win4.second", 2, 0, 1, 0);
    applyStimulus(0, 0, 0, 4, 1);

    // Zero length: every RUN cycle is its own window.
    $display("[TB] zero-length windows");
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 1, 1, 0, 1);
    checkOutput("len0.first", 1, 0, 1, 0);
    applyStimulus(0, 1, 1, 0, 1);
    checkOutput("len0.second", 0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0, 1);
    checkOutput("len0.third", 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);

    // Saturation: 300 rises overflow, exactly 255 rises do not.
    $display("[TB] saturation");
    applyStimulus(0, 1, 0, 600, 1);
    for (int i = 0; i < 600; i++) applyStimulus(0, 1, (i % 2) == 0, 600, 1);
    checkOutput("sat.300", 255, 1, 1, 0);
    applyStimulus(0, 0, 0, 600, 1);
    applyStimulus(0, 1, 0, 510, 1);
    for (int i = 0; i < 510; i++) applyStimulus(0, 1, (i % 2) == 0, 510, 1);
    checkOutput("sat.255", 255, 0, 1, 0);
    applyStimulus(0, 0, 0, 510, 1);

    // Back-pressure: second result dropped, third loads on the accept cycle.
    $display("[TB] back-pressure and drop");
    applyStimulus(0, 1, 0, 3, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 3, 0);
    checkOutput("bp.first", 0, 0, 1, 0);
    applyStimulus(0, 1, 1, 3, 0);
    applyStimulus(0, 1, 0, 3, 0);
    applyStimulus(0, 1, 1, 3, 0);
    checkOutput("bp.dropped", 0, 0, 1, 1);
    applyStimulus(0, 1, 0, 3, 0);
    applyStimulus(0, 1, 1, 3, 0);
    applyStimulus(0, 1, 0, 3, 1);
    checkOutput("bp.third", 1, 0, 1, 1);

    // Reset in the middle of a window with a held result and sticky drop.
    applyStimulus(0, 1, 1, 3, 0);
    applyStimulus(1, 1, 1, 3, 1);
    checkOutput("midreset", 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 5, 0);

    // Abort in cycle 2 of a length-5 window, then a fresh window.
    $display("[TB] abort and restart");
    applyStimulus(0, 1, 0, 5, 1);
    applyStimulus(0, 1, 1, 5, 1);
    applyStimulus(0, 0, 0, 5, 1);
    applyStimulus(0, 0, 0, 5, 1);
    checkOutput("abort", 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 5, 1);
    applyStimulus(0, 1, 1, 5, 1);
    applyStimulus(0, 1, 0, 5, 1);
    applyStimulus(0, 1, 0, 5, 1);
    applyStimulus(0, 1, 0, 5, 1);
    checkOutput("restart.pending", 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 5, 1);
    checkOutput("restart.done", 2, 0, 1, 0);

    // Mixed traffic: varying lengths, enable drops and ready stalls.
    $display("[TB] mixed traffic");
    for (int i = 0; i < 240; i++)
      applyStimulus(0, (i % 37) != 36, ((i * 5) % 7) > 2, (i / 40) % 4, ((i / 3) % 3) != 0);

    applyStimulus(0, 0, 0, 0, 1);
    checkOn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/pulse_window_counter.md
PULSE_WINDOW_COUNTER -- requirements
Module: pulse_window_counter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the event count width.
REQ-002 The block SHALL have parameter WIN_W, default 16, giving the window length width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 The block SHALL have port en  input  1  run enable; high = count windows back-to-back, low = abort/idle.
REQ-006 The block SHALL have port din  input  1  the pulse/level stream from the upstream sequential stage (its Y output).
REQ-007 The block SHALL have port win_len  input  WIN_W  window length in cycles; sampled at window start.
REQ-008 The block SHALL have port out_count  output  CNT_W  rising-edge count of the last completed window.
REQ-009 The block SHALL have port out_ovf  output  1  the count saturated in that window.
REQ-010 The block SHALL have port out_valid  output  1  result held in the output register.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 The block SHALL have port out_drop  output  1  sticky flag: a completed result was discarded.

Function
REQ-013 The block SHALL register din into din_q every cycle in every state; rise = din & ~din_q.
REQ-014 The FSM SHALL have two states, IDLE and RUN; IDLE -> RUN when en=1, RUN -> IDLE when en=0.
REQ-015 On entry to RUN and at every window restart, the block SHALL load remaining = win_len, or 1 when win_len=0, and clear the accumulator count and window ovf.
REQ-016 A window SHALL span exactly N consecutive RUN cycles (N = loaded length); the first is the IDLE->RUN transition cycle +1; rise in every one of the N cycles counts, including the last.
REQ-017 The count SHALL saturate at 2^CNT_W-1; a rise at saturation SHALL set window ovf and leave count unchanged.
REQ-018 In the Nth cycle, count (including that cycle's rise) and ovf SHALL be written to the output register, out_valid SHALL be 1 from the next cycle, and with en=1 the next window SHALL start in the next cycle with no gap.
REQ-019 out_count/out_ovf SHALL stay stable while out_valid=1; out_valid SHALL clear on the edge where out_valid & out_ready=1.
REQ-020 If a window completes while out_valid=1 and out_ready=0, the new result SHALL be discarded, the held result kept, and out_drop set.
REQ-021 If a window completes in the same cycle as an accept (out_valid & out_ready), the new result SHALL load and out_valid SHALL stay 1; out_drop unchanged.
REQ-022 en=0 in RUN SHALL abort the partial window: no result produced, counters discarded, IDLE next cycle; the output register and handshake SHALL be unaffected.
REQ-023 In IDLE no rises SHALL be counted and no results produced.
REQ-024 out_drop SHALL clear only on reset.

Reset
REQ-025 While rst=1 at a clock edge: state=IDLE, din_q=0, count=0, remaining=0, window ovf=0, out_count=0, out_ovf=0, out_valid=0, out_drop=0.
REQ-026 rst SHALL take priority over en, din and out_ready; reset mid-window SHALL discard the window and any held result.
REQ-027 After reset release, din=1 in the first counted RUN cycle SHALL count as a rise (din_q=0).

Verification
REQ-028 win_len=4, en=1, out_ready=1, din=1,0,1,0 -> out_valid pulses 1 cycle after window, out_count=2, out_ovf=0; next window follows with no gap.
REQ-029 CNT_W=8, win_len=600, din toggling every cycle (300 rises) -> out_count=255, out_ovf=1.
REQ-030 win_len=0 -> every RUN cycle is a 1-cycle window; din steady 1 -> out_count=0 each window except the first (=1).
REQ-031 win_len=3, out_ready=0 for two windows -> first result held, out_drop=1; out_ready=1 on the cycle a third window completes -> third result loaded, out_valid stays 1.
REQ-032 en=0 in cycle 2 of a win_len=5 window -> no out_valid; re-assert en -> fresh 5-cycle window, count from 0.
REQ-033 rst=1 mid-window with out_valid=1 and out_drop=1 -> next cycle all outputs 0, state IDLE.
